ws_systolic_array: RTL

Weight-stationary, parametrised ROWS×COLS systolic matrix-vector engine. It is the next-generation compute core behind the buffer/controller path.
- Adds on-chip weight load, input skew and output de-skew, a valid/ready stream interface with whole-array stall, a run-time signed/unsigned mode, and a load/compute/drain FSM.
- Each accepted activation vector `a` produces one aligned result vector: `res[j] = Σ_i a[i]·W[i][j]`.

---
 rtl/ws_array_pkg.sv | 36 +++
 rtl/ws_pe.sv | 55 +++++
 rtl/ws_systolic_array.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/ws_array_pkg.sv
`default_nettype none
// =============================================================================
// ws_array_pkg : shared types and helpers for the weight-stationary array
// Rev 1.0
// =============================================================================
package ws_array_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOAD    = 2'd1,
        COMPUTE = 2'd2,
        DRAIN   = 2'd3
    } state_t;

    localparam int c_EXT_W = 64;

    function automatic int latency(input int rows, input int cols);
        return rows + cols - 1;
    endfunction

    // Sign- or zero-extends the low `width` bits of data to c_EXT_W bits.
    function automatic logic [c_EXT_W-1:0] extend(input logic [c_EXT_W-1:0] data,
                                                   input int               width,
                                                   input logic             is_signed);
        logic [c_EXT_W-1:0] mask;
        logic [c_EXT_W-1:0] sh;
        mask = (width >= c_EXT_W) ? {c_EXT_W{1'b1}}
                                  : ((c_EXT_W'(1) << width) - c_EXT_W'(1));
        sh   = data >> (width - 1);
        if (is_signed && sh[0])
            return data | ~mask;
        return data & mask;
    endfunction

endpackage : ws_array_pkg
`default_nettype wire

// File: rtl/ws_pe.sv
`default_nettype none
// =============================================================================
// ws_pe : one processing element holding a stationary weight; psum += a*w
// Rev 1.0
// =============================================================================
module ws_pe
    import ws_array_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ACC_WIDTH  = 24
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_en,
    input  logic                  i_w_load,
    input  logic                  i_is_signed,
    input  logic [DATA_WIDTH-1:0] i_w_in,
    input  logic [DATA_WIDTH-1:0] i_a_in,
    input  logic [ACC_WIDTH-1:0]  i_psum_in,
    output logic [DATA_WIDTH-1:0] o_a_out,
    output logic [ACC_WIDTH-1:0]  o_psum_out
);

    logic [DATA_WIDTH-1:0] r_w;
    logic [DATA_WIDTH-1:0] r_a;
    logic [ACC_WIDTH-1:0]  r_psum;
    logic [ACC_WIDTH-1:0]  w_a_ext;
    logic [ACC_WIDTH-1:0]  w_w_ext;
    logic [ACC_WIDTH-1:0]  w_prod;

    assign w_a_ext = ACC_WIDTH'(extend(c_EXT_W'(i_a_in), DATA_WIDTH, i_is_signed));
    assign w_w_ext = ACC_WIDTH'(extend(c_EXT_W'(r_w), DATA_WIDTH, i_is_signed));
    // Truncated product is exact modulo 2^ACC_WIDTH for both signednesses.
    assign w_prod  = w_a_ext * w_w_ext;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_w    <= '0;
            r_a    <= '0;
            r_psum <= '0;
        end else begin
            if (i_w_load)
                r_w <= i_w_in;
            if (i_en) begin
                r_a    <= i_a_in;
                r_psum <= i_psum_in + w_prod;
            end
        end
    end

    assign o_a_out    = r_a;
    assign o_psum_out = r_psum;

endmodule : ws_pe
`default_nettype wire

// File: rtl/ws_systolic_array.sv
`default_nettype none
// =============================================================================
// ws_systolic_array : ROWSxCOLS weight-stationary matrix-vector engine
// Rev 1.0
// =============================================================================
module ws_systolic_array
    import ws_array_pkg::*;
#(
    parameter int ROWS       = 4,
    parameter int COLS       = 4,
    parameter int DATA_WIDTH = 8,
    parameter int ACC_WIDTH  = 24
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       i_is_signed,
    input  logic                       i_w_valid,
    output logic                       o_w_ready,
    input  logic [COLS*DATA_WIDTH-1:0] i_w_row,
    input  logic                       i_a_valid,
    output logic                       o_a_ready,
    input  logic [ROWS*DATA_WIDTH-1:0] i_a_vec,
    input  logic                       i_a_last,
    output logic                       o_res_valid,
    input  logic                       i_res_ready,
    output logic [COLS*ACC_WIDTH-1:0]  o_res_vec,
    output logic                       o_res_last,
    output logic                       o_busy
);

    localparam int c_LAT   = latency(ROWS, COLS);
    localparam int c_CNT_W = (ROWS > 1) ? $clog2(ROWS) : 1;

    state_t               r_state;
    state_t               w_next;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [c_CNT_W-1:0]   w_wr_row;
    logic                 r_is_signed;
    logic                 w_adv;
    logic                 w_w_acc;
    logic                 w_a_acc;
    logic [c_LAT-1:0]     r_vld;
    logic [c_LAT-1:0]     r_lst;

    logic [DATA_WIDTH-1:0] w_a        [ROWS][COLS];
    logic [DATA_WIDTH-1:0] w_a_unused [ROWS];
    logic [ACC_WIDTH-1:0]  w_ps       [ROWS+1][COLS];

    // Whole-array stall: every pipeline register holds while a result waits.
    assign w_adv       = !r_vld[c_LAT-1] | i_res_ready;
    assign o_res_valid = r_vld[c_LAT-1];
    assign o_res_last  = r_lst[c_LAT-1];
    assign w_w_acc     = i_w_valid & o_w_ready;
    assign w_a_acc     = i_a_valid & o_a_ready;
    assign o_busy      = (r_state != IDLE);
    assign w_wr_row    = (r_state == IDLE) ? '0 : r_cnt;

    always_comb begin
        w_next    = r_state;
        o_w_ready = 1'b0;
        o_a_ready = 1'b0;
        case (r_state)
            IDLE: begin
                o_w_ready = 1'b1;
                if (i_w_valid)
                    w_next = (ROWS == 1) ? COMPUTE : LOAD;
            end
            LOAD: begin
                o_w_ready = 1'b1;
                if (i_w_valid && (r_cnt == c_CNT_W'(ROWS - 1)))
                    w_next = COMPUTE;
            end
            COMPUTE: begin
                o_a_ready = w_adv;
                if (i_a_valid && w_adv && i_a_last)
                    w_next = DRAIN;
            end
            DRAIN: begin
                if (o_res_valid && i_res_ready && o_res_last)
                    w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_is_signed <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == IDLE && w_w_acc) begin
                r_is_signed <= i_is_signed;
                r_cnt       <= c_CNT_W'(1);
            end else if (r_state == LOAD && w_w_acc) begin
                r_cnt <= r_cnt + c_CNT_W'(1);
            end
        end
    end

    // Valid/last tags travel alongside the data wavefront.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld <= '0;
            r_lst <= '0;
        end else if (w_adv) begin
            r_vld <= c_LAT'({r_vld, w_a_acc});
            r_lst <= c_LAT'({r_lst, w_a_acc & i_a_last});
        end
    end

    generate
        for (genvar i = 0; i < ROWS; i++) begin : g_skew
            logic [DATA_WIDTH-1:0] w_inj;
            assign w_inj = w_a_acc ? i_a_vec[i*DATA_WIDTH +: DATA_WIDTH] : '0;
            if (i == 0) begin : g_direct
                assign w_a[i][0] = w_inj;
            end else begin : g_delay
                logic [DATA_WIDTH-1:0] r_sk [i];
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        for (int k = 0; k < i; k++)
                            r_sk[k] <= '0;
                    end else if (w_adv) begin
                        r_sk[0] <= w_inj;
                        for (int k = 1; k < i; k++)
                            r_sk[k] <= r_sk[k-1];
                    end
                end
                assign w_a[i][0] = r_sk[i-1];
            end
        end

        for (genvar j = 0; j < COLS; j++) begin : g_ps0
            assign w_ps[0][j] = '0;
        end

        for (genvar i = 0; i < ROWS; i++) begin : g_row
            for (genvar j = 0; j < COLS; j++) begin : g_col
                logic                  w_load;
                logic [DATA_WIDTH-1:0] w_a_out;
                assign w_load = w_w_acc && (w_wr_row == c_CNT_W'(i));

                ws_pe #(
                    .DATA_WIDTH (DATA_WIDTH),
                    .ACC_WIDTH  (ACC_WIDTH)
                ) u_pe (
                    .clk         (clk),
                    .rst_n       (rst_n),
                    .i_en        (w_adv),
                    .i_w_load    (w_load),
                    .i_is_signed (r_is_signed),
                    .i_w_in      (i_w_row[j*DATA_WIDTH +: DATA_WIDTH]),
                    .i_a_in      (w_a[i][j]),
                    .i_psum_in   (w_ps[i][j]),
                    .o_a_out     (w_a_out),
                    .o_psum_out  (w_ps[i+1][j])
                );

                if (j < COLS - 1) begin : g_fwd
                    assign w_a[i][j+1] = w_a_out;
                end else begin : g_edge
                    assign w_a_unused[i] = w_a_out;
                end
            end
        end

        for (genvar j = 0; j < COLS; j++) begin : g_deskew
            localparam int c_D = COLS - 1 - j;
            if (c_D == 0) begin : g_direct
                assign o_res_vec[j*ACC_WIDTH +: ACC_WIDTH] = w_ps[ROWS][j];
            end else begin : g_delay
                logic [ACC_WIDTH-1:0] r_ds [c_D];
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        for (int k = 0; k < c_D; k++)
                            r_ds[k] <= '0;
                    end else if (w_adv) begin
                        r_ds[0] <= w_ps[ROWS][j];
                        for (int k = 1; k < c_D; k++)
                            r_ds[k] <= r_ds[k-1];
                    end
                end
                assign o_res_vec[j*ACC_WIDTH +: ACC_WIDTH] = r_ds[c_D-1];
            end
        end
    endgenerate

endmodule : ws_systolic_array
`default_nettype wire
